freepdk45_sram_1w1r_param: RTL and testbench
============================================

Name: freepdk45_sram_1w1r_param

Overview:
Synthesizable, parametrised single-clock 1-write/1-read SRAM macro model. It is the next-generation replacement for the fixed-size 1W1R macro models.
- Adds per-lane write masks and a configurable read latency (1 or 2 cycles).
- Adds a defined same-address read/write collision policy with a collision flag.
- Adds a dout valid strobe and an async active-low reset of the output pipeline.
- Sits between datapath FIFOs/caches and the memory array in the FreePDK45 flow.

Parameters:
DATA_WIDTH, 40, bits per word.
ADDR_WIDTH, 7, address bits; depth = 2**ADDR_WIDTH.
WMASK_WIDTH, 5, number of write-mask lanes; lane width G = DATA_WIDTH/WMASK_WIDTH; DATA_WIDTH must be divisible by WMASK_WIDTH (elaboration error otherwise).
READ_LATENCY, 1, accepted-read-to-data cycles; legal values 1 or 2 only (elaboration error otherwise).
BYPASS, 1, same-edge same-address collision policy: 1 = return new (merged) data; 0 = return old data.

Ports:
clk0  input  1  single clock; all state updates on posedge.
rstb0  input  1  asynchronous, active-low reset.
csb0  input  1  write port select, active low.
addr0  input  ADDR_WIDTH  write address.
din0  input  DATA_WIDTH  write data.
wmask0  input  WMASK_WIDTH  lane enables; bit i covers din0[i*G +: G].
csb1  input  1  read port select, active low.
addr1  input  ADDR_WIDTH  read address.
dout1  output  DATA_WIDTH  read data.
dvalid1  output  1  one-cycle pulse; dout1 holds a newly returned word.
coll1  output  1  qualifies dvalid1; returned word was a same-edge same-address collision.

Behaviour:
- One clock (clk0); reset is asynchronous and active-low (rstb0).
- Reset, while rstb0=0:
  - dout1=0, dvalid1=0, coll1=0; all read-pipeline valid bits cleared.
  - No writes commit; array contents are not reset and are retained across reset.
  - Words never written read back as X in simulation.
- Write:
  - Accepted at a posedge with csb0=0.
  - Lanes with wmask0[i]=1 are updated at that same edge; other lanes keep their old value.
  - wmask0=0 with csb0=0 is a no-op write.
  - Written data is visible to any read accepted at a later edge.
- Read:
  - Accepted at a posedge with csb1=0; the array is sampled at the acceptance edge.
  - READ_LATENCY=1: word registered at the acceptance edge; dout1/dvalid1 valid for the cycle after it.
  - READ_LATENCY=2: one extra register stage; dout1/dvalid1 valid one cycle later.
  - Back-to-back reads are accepted every cycle; throughput is 1 word/cycle.
- dout1 holds the last returned word when no new word arrives; it never goes to X from bubbles.
- dvalid1 is high exactly one cycle per accepted read.
- Collision: csb0=0, csb1=0 and addr0==addr1 at the same edge.
  - BYPASS=1: returned word = write-merged word (masked lanes from din0, others old).
  - BYPASS=0: returned word = pre-write contents.
  - coll1=1 alongside that read's dvalid1. A zero-mask write still counts as a collision; the data equals the old word.
- A write at a later edge to an address already read never alters the in-flight read data, which was captured at acceptance.
- Address wrap: addresses are full-range; no out-of-range condition exists.
- Reset mid-operation:
  - In-flight reads are dropped; no dvalid1 pulse is issued for them.
  - After rstb0 deasserts, the first accepted edge behaves normally.
- No $display side effects in the synthesizable path. Simulation-only collision warnings are allowed under a define.

Test Plan:
1. Reset, then write 0x12_3456_789A to addr 5 (wmask0=5'h1F); read addr 5 next cycle -> dvalid1 pulses one cycle after read acceptance (READ_LATENCY=1), dout1=0x12_3456_789A, coll1=0.
2. Write 0xFF_FFFF_FFFF to addr 3, then write 0x00_0000_0000 with wmask0=5'b00101 -> read addr 3 returns 0xFF_FF00_FF00.
3. Same edge: write 0xAA_AAAA_AAAA to addr 7 (old 0x11_1111_1111), read addr 7 -> BYPASS=1: dout1=0xAA_AAAA_AAAA with coll1=1; BYPASS=0: dout1=0x11_1111_1111 with coll1=1.
4. READ_LATENCY=2: reads of addrs 0,1,2,3 on consecutive cycles (preloaded 0x10..0x13) -> dvalid1 high for 4 consecutive cycles starting two cycles after the first acceptance, data 0x10,0x11,0x12,0x13 in order; dout1 holds 0x13 afterwards with dvalid1=0.
5. Two reads in flight (READ_LATENCY=2), assert rstb0 asynchronously mid-cycle -> dout1=0 and dvalid1=0 immediately; no pulses after release; previously written words still read back correctly.
6. Write addr 9 with csb0=1 (deselected), then read addr 9 -> returns the prior contents unchanged; dvalid1 pulses, coll1=0.

Source files
------------

// File: rtl/freepdk45_sram_1w1r_param.sv
// ---------------------------------------------------------------------------
// freepdk45_sram_1w1r_param
// Parametrised single-clock 1-write / 1-read SRAM macro model.
//
// Ports
//   clk0     single clock, all state changes on posedge
//   rstb0    asynchronous active-low reset of the read output pipeline
//   csb0     write port select (active low)
//   addr0    write address
//   din0     write data
//   wmask0   write lane enables, bit i covers din0[i*G +: G]
//   csb1     read port select (active low)
//   addr1    read address
//   dout1    read data, holds the last returned word between reads
//   dvalid1  one-cycle strobe: dout1 carries a newly returned word
//   coll1    qualifies dvalid1: that word came from a same-edge,
//            same-address read/write collision
//
// The array itself is never reset; only the read pipeline is.
// ---------------------------------------------------------------------------
module freepdk45_sram_1w1r_param #(
    parameter int DATA_WIDTH   = 40,
    parameter int ADDR_WIDTH   = 7,
    parameter int WMASK_WIDTH  = 5,
    parameter int READ_LATENCY = 1,
    parameter bit BYPASS       = 1'b1
) (
    input  logic                   clk0,
    input  logic                   rstb0,
    input  logic                   csb0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   dvalid1,
    output logic                   coll1
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int G     = DATA_WIDTH / WMASK_WIDTH;

    if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_mask_width
        $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  coll_now;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_coll;

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_coll;

    assign wr_acc   = ~csb0;
    assign rd_acc   = ~csb1;
    assign coll_now = wr_acc && rd_acc && (addr0 == addr1);

    // Word that the write port will leave in the array: enabled lanes
    // from din0, the rest from the current contents.
    always_comb begin
        merged_word = mem[addr0];
        for (int i = 0; i < WMASK_WIDTH; i++) begin
            if (wmask0[i]) begin
                merged_word[i*G +: G] = din0[i*G +: G];
            end
        end
    end

    // On a collision the read either forwards the merged write word or
    // sees the pre-write contents, selected by BYPASS.
    always_comb begin
        rd_word = mem[addr1];
        if (coll_now && BYPASS) begin
            rd_word = merged_word;
        end
    end

    // Array writes are blocked while reset is held; contents survive reset.
    always_ff @(posedge clk0) begin
        if (rstb0 && wr_acc) begin
            mem[addr0] <= merged_word;
        end
    end

    // Source of the output register: the acceptance edge itself for
    // latency 1, or the extra stage for latency 2.
    always_comb begin
        if (READ_LATENCY == 1) begin
            out_valid = rd_acc;
            out_data  = rd_word;
            out_coll  = coll_now;
        end else begin
            out_valid = s1_valid;
            out_data  = s1_data;
            out_coll  = s1_coll;
        end
    end

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_coll  <= 1'b0;
            dout1    <= '0;
            dvalid1  <= 1'b0;
            coll1    <= 1'b0;
        end else begin
            s1_valid <= rd_acc;
            if (rd_acc) begin
                s1_data <= rd_word;
                s1_coll <= coll_now;
            end
            dvalid1 <= out_valid;
            coll1   <= out_valid && out_coll;
            // dout1 only moves on a real return so bubbles never disturb it.
            if (out_valid) begin
                dout1 <= out_data;
            end
        end
    end

endmodule

// File: tb/tb_freepdk45_sram_1w1r_param.sv
module tb_freepdk45_sram_1w1r_param;

    logic        clk0;
    logic        rstb0;
    logic        csb0;
    logic [6:0]  addr0;
    logic [39:0] din0;
    logic [4:0]  wmask0;
    logic        csb1;
    logic [6:0]  addr1;

    // a: READ_LATENCY=1, BYPASS=1   b: READ_LATENCY=2, BYPASS=0
    logic [39:0] dout_a, dout_b;
    logic        dvalid_a, dvalid_b;
    logic        coll_a, coll_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic [39:0] d;
        logic        c;
    } rd_t;

    rd_t         qa[$];
    rd_t         qb[$];
    logic [39:0] mem_m [128];

    logic        ea_v = 1'b0, eb_v = 1'b0;
    logic        ea_c = 1'b0, eb_c = 1'b0;
    logic [39:0] ea_d = '0,   eb_d = '0;

    freepdk45_sram_1w1r_param dut_a (
        .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .addr0(addr0), .din0(din0),
        .wmask0(wmask0), .csb1(csb1), .addr1(addr1),
        .dout1(dout_a), .dvalid1(dvalid_a), .coll1(coll_a)
    );

    freepdk45_sram_1w1r_param #(.READ_LATENCY(2), .BYPASS(1'b0)) dut_b (
        .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .addr0(addr0), .din0(din0),
        .wmask0(wmask0), .csb1(csb1), .addr1(addr1),
        .dout1(dout_b), .dvalid1(dvalid_b), .coll1(coll_b)
    );

    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    // Advance one edge and update the reference model from the inputs
    // present at that edge; returns 1 time unit after the edge.
    task automatic tick();
        logic [39:0] m, old_w, old_r, merged;
        logic        c;
        rd_t         e;
        @(posedge clk0);
        if (rstb0) begin
            m = '0;
            for (int i = 0; i < 5; i++) if (wmask0[i]) m[i*8 +: 8] = 8'hFF;
            old_w  = mem_m[addr0];
            merged = (old_w & ~m) | (din0 & m);
            if (!csb1) begin
                old_r = mem_m[addr1];
                c     = !csb0 && (addr0 == addr1);
                e.due = cyc + 1; e.d = c ? merged : old_r; e.c = c; qa.push_back(e);
                e.due = cyc + 2; e.d = old_r;              e.c = c; qb.push_back(e);
            end
            if (!csb0) mem_m[addr0] = merged;
        end
        cyc++;
        ea_v = 1'b0; ea_c = 1'b0;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            ea_v = 1'b1; ea_c = qa[0].c; ea_d = qa[0].d; void'(qa.pop_front());
        end
        eb_v = 1'b0; eb_c = 1'b0;
        if (qb.size() > 0 && qb[0].due == cyc) begin
            eb_v = 1'b1; eb_c = qb[0].c; eb_d = qb[0].d; void'(qb.pop_front());
        end
        #1;
    endtask

    task automatic idle();
        csb0 = 1'b1; csb1 = 1'b1; wmask0 = '0;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [39:0] d, input logic [4:0] m);
        csb0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
        tick();
        csb0 = 1'b1;
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete();
        ea_v = 1'b0; ea_c = 1'b0; ea_d = '0;
        eb_v = 1'b0; eb_c = 1'b0; eb_d = '0;
    endtask

    task automatic test_reset();
        rstb0 = 1'b0;
        idle();
        addr0 = '0; addr1 = '0; din0 = '0;
        model_reset();
        #23;
        total++; if (dout_a !== 40'h0) begin bad++; $display("FAIL reset_dout_a got=%h want=0", dout_a); end
        total++; if (dvalid_a !== 1'b0) begin bad++; $display("FAIL reset_dvalid_a got=%b want=0", dvalid_a); end
        total++; if (coll_a !== 1'b0) begin bad++; $display("FAIL reset_coll_a got=%b want=0", coll_a); end
        total++; if (dout_b !== 40'h0) begin bad++; $display("FAIL reset_dout_b got=%h want=0", dout_b); end
        total++; if (dvalid_b !== 1'b0) begin bad++; $display("FAIL reset_dvalid_b got=%b want=0", dvalid_b); end
        rstb0 = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_write(7'd5, 40'h12_3456_789A, 5'h1F);
        csb1 = 1'b0; addr1 = 7'd5;
        tick();
        csb1 = 1'b1;
        total++; if (dvalid_a !== 1'b1 || dout_a !== 40'h12_3456_789A || coll_a !== 1'b0) begin
            bad++; $display("FAIL basic_a got v=%b d=%h c=%b want v=1 d=123456789a c=0", dvalid_a, dout_a, coll_a); end
        total++; if (dvalid_b !== 1'b0) begin bad++; $display("FAIL basic_b_early got v=%b want v=0", dvalid_b); end
        tick();
        total++; if (dvalid_a !== 1'b0 || dout_a !== 40'h12_3456_789A) begin
            bad++; $display("FAIL basic_a_hold got v=%b d=%h want v=0 d=123456789a", dvalid_a, dout_a); end
        total++; if (dvalid_b !== 1'b1 || dout_b !== 40'h12_3456_789A || coll_b !== 1'b0) begin
            bad++; $display("FAIL basic_b got v=%b d=%h c=%b want v=1 d=123456789a c=0", dvalid_b, dout_b, coll_b); end
        tick();
        total++; if (dvalid_b !== 1'b0) begin bad++; $display("FAIL basic_b_pulse got v=%b want v=0", dvalid_b); end
    endtask

    task automatic test_mask();
        do_write(7'd3, 40'hFF_FFFF_FFFF, 5'h1F);
        do_write(7'd3, 40'h00_0000_0000, 5'b00101);
        csb1 = 1'b0; addr1 = 7'd3;
        tick();
        csb1 = 1'b1;
        total++; if (dvalid_a !== 1'b1 || dout_a !== 40'hFF_FF00_FF00) begin
            bad++; $display("FAIL mask_a got v=%b d=%h want v=1 d=ffff00ff00", dvalid_a, dout_a); end
        tick();
        total++; if (dvalid_b !== 1'b1 || dout_b !== 40'hFF_FF00_FF00) begin
            bad++; $display("FAIL mask_b got v=%b d=%h want v=1 d=ffff00ff00", dvalid_b, dout_b); end
    endtask

    task automatic test_collision();
        do_write(7'd7, 40'h11_1111_1111, 5'h1F);
        csb0 = 1'b0; addr0 = 7'd7; din0 = 40'hAA_AAAA_AAAA; wmask0 = 5'h1F;
        csb1 = 1'b0; addr1 = 7'd7;
        tick();
        idle();
        total++; if (dvalid_a !== 1'b1 || dout_a !== 40'hAA_AAAA_AAAA || coll_a !== 1'b1) begin
            bad++; $display("FAIL coll_new_a got v=%b d=%h c=%b want v=1 d=aaaaaaaaaa c=1", dvalid_a, dout_a, coll_a); end
        tick();
        total++; if (dvalid_b !== 1'b1 || dout_b !== 40'h11_1111_1111 || coll_b !== 1'b1) begin
            bad++; $display("FAIL coll_old_b got v=%b d=%h c=%b want v=1 d=1111111111 c=1", dvalid_b, dout_b, coll_b); end
        total++; if (coll_a !== 1'b0) begin bad++; $display("FAIL coll_a_clear got=%b want=0", coll_a); end
        // zero-mask write still flags a collision but leaves data unchanged
        csb0 = 1'b0; addr0 = 7'd7; din0 = 40'h55_5555_5555; wmask0 = 5'h00;
        csb1 = 1'b0; addr1 = 7'd7;
        tick();
        idle();
        total++; if (dvalid_a !== 1'b1 || dout_a !== 40'hAA_AAAA_AAAA || coll_a !== 1'b1) begin
            bad++; $display("FAIL coll_zero_a got v=%b d=%h c=%b want v=1 d=aaaaaaaaaa c=1", dvalid_a, dout_a, coll_a); end
        tick();
        total++; if (dvalid_b !== 1'b1 || dout_b !== 40'hAA_AAAA_AAAA || coll_b !== 1'b1) begin
            bad++; $display("FAIL coll_zero_b got v=%b d=%h c=%b want v=1 d=aaaaaaaaaa c=1", dvalid_b, dout_b, coll_b); end
    endtask

    task automatic test_burst();
        logic [39:0] want;
        for (int i = 0; i < 4; i++) do_write(7'(i), 40'h10 + 40'(i), 5'h1F);
        csb1 = 1'b0; addr1 = 7'd0;
        tick();
        total++; if (dvalid_b !== 1'b0) begin bad++; $display("FAIL burst_b_first got v=%b want v=0", dvalid_b); end
        for (int i = 1; i < 5; i++) begin
            if (i < 4) addr1 = 7'(i); else csb1 = 1'b1;
            tick();
            want = 40'h10 + 40'(i - 1);
            total++; if (dvalid_b !== 1'b1 || dout_b !== want) begin
                bad++; $display("FAIL burst_b[%0d] got v=%b d=%h want v=1 d=%h", i - 1, dvalid_b, dout_b, want); end
            total++; if (dvalid_a !== ea_v || dout_a !== ea_d) begin
                bad++; $display("FAIL burst_a[%0d] got v=%b d=%h want v=%b d=%h", i, dvalid_a, dout_a, ea_v, ea_d); end
        end
        tick();
        total++; if (dvalid_b !== 1'b0 || dout_b !== 40'h13) begin
            bad++; $display("FAIL burst_b_hold got v=%b d=%h want v=0 d=13", dvalid_b, dout_b); end
    endtask

    task automatic preload();
        for (int a = 0; a < 128; a++) do_write(7'(a), {8'($urandom), 32'($urandom)}, 5'h1F);
        tick();
        tick();
    endtask

    task automatic test_deselect();
        logic [39:0] prior;
        prior = mem_m[9];
        csb0 = 1'b1; addr0 = 7'd9; din0 = ~prior; wmask0 = 5'h1F;
        csb1 = 1'b1;
        tick();
        csb1 = 1'b0; addr1 = 7'd9;
        tick();
        idle();
        total++; if (dvalid_a !== 1'b1 || dout_a !== prior || coll_a !== 1'b0) begin
            bad++; $display("FAIL desel_a got v=%b d=%h c=%b want v=1 d=%h c=0", dvalid_a, dout_a, coll_a, prior); end
        tick();
        total++; if (dvalid_b !== 1'b1 || dout_b !== prior || coll_b !== 1'b0) begin
            bad++; $display("FAIL desel_b got v=%b d=%h c=%b want v=1 d=%h c=0", dvalid_b, dout_b, coll_b, prior); end
        tick();
    endtask

    task automatic test_reset_midflight();
        csb1 = 1'b0; addr1 = 7'd20;
        tick();
        addr1 = 7'd21;
        tick();
        csb1 = 1'b1;
        #2 rstb0 = 1'b0;
        model_reset();
        #1;
        total++; if (dout_a !== 40'h0 || dvalid_a !== 1'b0 || dout_b !== 40'h0 || dvalid_b !== 1'b0) begin
            bad++; $display("FAIL rst_async got a=%b/%h b=%b/%h want 0/0", dvalid_a, dout_a, dvalid_b, dout_b); end
        tick();
        tick();
        #2 rstb0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (dvalid_a !== 1'b0 || dvalid_b !== 1'b0 || dout_a !== 40'h0 || dout_b !== 40'h0) begin
                bad++; $display("FAIL rst_no_pulse[%0d] got a=%b/%h b=%b/%h want 0/0", i, dvalid_a, dout_a, dvalid_b, dout_b); end
        end
        csb1 = 1'b0; addr1 = 7'd20;
        tick();
        addr1 = 7'd21;
        total++; if (dvalid_a !== 1'b1 || dout_a !== mem_m[20]) begin
            bad++; $display("FAIL rst_after_a got v=%b d=%h want v=1 d=%h", dvalid_a, dout_a, mem_m[20]); end
        tick();
        csb1 = 1'b1;
        total++; if (dvalid_b !== 1'b1 || dout_b !== mem_m[20] || dout_a !== mem_m[21]) begin
            bad++; $display("FAIL rst_after_b got b=%h a=%h want b=%h a=%h", dout_b, dout_a, mem_m[20], mem_m[21]); end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 400; n++) begin
            csb0   = ($urandom_range(0, 3) == 0);
            csb1   = ($urandom_range(0, 3) == 0);
            addr0  = (n < 200) ? 7'($urandom_range(0, 7)) : 7'($urandom);
            addr1  = (n < 200) ? 7'($urandom_range(0, 7)) : 7'($urandom);
            din0   = {8'($urandom), 32'($urandom)};
            wmask0 = 5'($urandom);
            tick();
            total++; if (dvalid_a !== ea_v || dout_a !== ea_d || coll_a !== ea_c) begin
                bad++; $display("FAIL rand_a[%0d] got v=%b d=%h c=%b want v=%b d=%h c=%b",
                                n, dvalid_a, dout_a, coll_a, ea_v, ea_d, ea_c); end
            total++; if (dvalid_b !== eb_v || dout_b !== eb_d || coll_b !== eb_c) begin
                bad++; $display("FAIL rand_b[%0d] got v=%b d=%h c=%b want v=%b d=%h c=%b",
                                n, dvalid_b, dout_b, coll_b, eb_v, eb_d, eb_c); end
        end
        idle();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_collision();
        test_burst();
        preload();
        test_deselect();
        test_reset_midflight();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
